aes_inv_add_round_key: RTL and testbench

//  AddRoundKey stage of the iterative AES decrypt datapath. Holds the expanded key schedule
//  and tracks the round counter. Each accepted 128-bit state is XORed with the key for the

---
 rtl/aes_pkg.sv | 22 ++
 rtl/aes_key_store.sv | 43 ++++
 rtl/aes_inv_add_round_key.sv | 120 ++++++++++++
 tb/tb_aes_inv_add_round_key.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | aes_pkg                                                              |
// | Shared AES round counts, word/state types and round-key indexing.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package aes_pkg;

  localparam int AES_NR_128 = 10;
  localparam int AES_NR_192 = 12;
  localparam int AES_NR_256 = 14;

  typedef logic [31:0]  aes_word_t;
  typedef logic [127:0] aes_state_t;

  // Word index of column col of roundkey[rnd], i.e. 4*rnd + col.
  function automatic logic [5:0] aes_rk_word_idx(input logic [3:0] rnd, input logic [1:0] col);
    return {rnd, col};
  endfunction

endpackage
`default_nettype wire

// File: rtl/aes_key_store.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | aes_key_store                                                        |
// | Expanded key schedule flop array: one word write port, one 4-word    |
// | round-key read port.                                                 |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module aes_key_store
  import aes_pkg::*;
#(
  parameter int NR = AES_NR_128,
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  aes_word_t     wr_data_i,
  input  logic [3:0]    rnd_i,
  output aes_state_t    rk_o
);

  localparam int DEPTH = 4 * (NR + 1);

  aes_word_t mem_q [DEPTH];

  // Caller guarantees wr_addr_i < DEPTH whenever wr_en_i is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  for (genvar c = 0; c < 4; c++) begin : g_col
    assign rk_o[127-32*c -: 32] = mem_q[AW'(aes_rk_word_idx(rnd_i, 2'(c)))];
  end

endmodule
`default_nettype wire

// File: rtl/aes_inv_add_round_key.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | aes_inv_add_round_key                                                |
// | AddRoundKey stage of the iterative AES decrypt datapath with round   |
// | counter, key schedule store and registered valid/ready output.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module aes_inv_add_round_key
  import aes_pkg::*;
#(
  parameter int NR = AES_NR_128,
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          key_wr_en,
  input  logic [AW-1:0] key_wr_addr,
  input  logic [31:0]   key_wr_data,
  output logic          key_err,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [127:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [127:0]  out_data,
  output logic [3:0]    out_round,
  output logic          out_mix,
  output logic          out_last
);

  localparam int          DEPTH   = 4 * (NR + 1);
  localparam logic [3:0]  NR_RND  = 4'(NR);
  localparam logic [AW:0] DEPTH_A = (AW+1)'(DEPTH);

  logic [3:0] rnd_q, rnd_d;
  logic       out_valid_q, out_valid_d;
  aes_state_t out_data_q, out_data_d;
  logic [3:0] out_round_q, out_round_d;
  logic       out_mix_q, out_mix_d;
  logic       out_last_q, out_last_d;
  logic       key_err_q, key_err_d;

  logic       w_idle;
  logic       w_key_ok;
  logic       w_accept;
  aes_state_t w_rk;

  // Keys may only change between blocks so a block never sees a mixed schedule.
  assign w_idle   = (rnd_q == NR_RND) && !out_valid_q;
  assign w_key_ok = key_wr_en && w_idle && ({1'b0, key_wr_addr} < DEPTH_A);
  assign in_ready = !flush && (!out_valid_q || out_ready);
  assign w_accept = in_valid && in_ready;

  aes_key_store #(
    .NR (NR),
    .AW (AW)
  ) u_key_store (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (w_key_ok),
    .wr_addr_i (key_wr_addr),
    .wr_data_i (key_wr_data),
    .rnd_i     (rnd_q),
    .rk_o      (w_rk)
  );

  always_comb begin
    rnd_d       = rnd_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_round_d = out_round_q;
    out_mix_d   = out_mix_q;
    out_last_d  = out_last_q;
    key_err_d   = key_wr_en && !w_key_ok;

    if (flush) begin
      out_valid_d = 1'b0;
      rnd_d       = NR_RND;
    end else if (w_accept) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data ^ w_rk;
      out_round_d = rnd_q;
      out_mix_d   = (rnd_q != 4'd0) && (rnd_q != NR_RND);
      out_last_d  = (rnd_q == 4'd0);
      rnd_d       = (rnd_q == 4'd0) ? NR_RND : rnd_q - 4'd1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rnd_q       <= NR_RND;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_round_q <= '0;
      out_mix_q   <= 1'b0;
      out_last_q  <= 1'b0;
      key_err_q   <= 1'b0;
    end else begin
      rnd_q       <= rnd_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_round_q <= out_round_d;
      out_mix_q   <= out_mix_d;
      out_last_q  <= out_last_d;
      key_err_q   <= key_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_round = out_round_q;
  assign out_mix   = out_mix_q;
  assign out_last  = out_last_q;
  assign key_err   = key_err_q;

endmodule
`default_nettype wire

// File: tb/tb_aes_inv_add_round_key.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_aes_inv_add_round_key                                             |
// | Directed bench: FIPS-197 C.1 decrypt through the AddRoundKey stage.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_aes_inv_add_round_key;

  localparam logic [127:0] C_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C_R10 = 128'h7ad5fda789ef4e272bca100b3d9ff59f;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         flush;
  logic         key_wr_en;
  logic [5:0]   key_wr_addr;
  logic [31:0]  key_wr_data;
  logic         key_err;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic [3:0]   out_round;
  logic         out_mix;
  logic         out_last;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  sbox_t [256];
  logic [7:0]  isbox_t [256];
  logic [31:0] w_m [44];

  always #5 clk = ~clk;

  aes_inv_add_round_key #(
    .NR (10),
    .AW (6)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .key_wr_en   (key_wr_en),
    .key_wr_addr (key_wr_addr),
    .key_wr_data (key_wr_data),
    .key_err     (key_err),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_round   (out_round),
    .out_mix     (out_mix),
    .out_last    (out_last)
  );

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
      bb = {1'b0, bb[7:1]};
    end
    return p;
  endfunction

  task automatic build_tables();
    logic [7:0] inv, t, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      s = inv; t = inv;
      for (int k = 0; k < 4; k++) begin
        t = {t[6:0], t[7]};
        s = s ^ t;
      end
      s = s ^ 8'h63;
      sbox_t[x]  = s;
      isbox_t[s] = 8'(x);
    end
  endtask

  task automatic build_keys();
    logic [31:0] t;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w_m[i] = C_KEY[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w_m[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]} ^ {rcon, 24'h0};
        rcon = rcon[7] ? ({rcon[6:0], 1'b0} ^ 8'h1b) : {rcon[6:0], 1'b0};
      end
      w_m[i] = w_m[i-4] ^ t;
    end
  endtask

  function automatic logic [127:0] rk(input int r);
    return {w_m[4*r], w_m[4*r+1], w_m[4*r+2], w_m[4*r+3]};
  endfunction

  function automatic logic [127:0] inv_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_sub(input logic [127:0] s);
    logic [127:0] o;
    for (int k = 0; k < 16; k++) o[127-8*k -: 8] = isbox_t[s[127-8*k -: 8]];
    return o;
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8]; a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8]; a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      o[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      o[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      o[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
    return o;
  endfunction

  task automatic do_flush();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  task automatic load_keys();
    for (int i = 0; i < 44; i++) begin
      key_wr_en = 1'b1; key_wr_addr = 6'(i); key_wr_data = w_m[i];
      @(posedge clk); #1;
    end
    key_wr_en = 1'b0;
    check("key_err_on_load", key_err, 0);
  endtask

  task automatic send(input logic [127:0] d, output logic [127:0] o, output logic [3:0] r,
                      output logic m, output logic l);
    int n;
    in_valid = 1'b1; in_data = d; out_ready = 1'b1; n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("send_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("send_out_valid", out_valid, 1);
    o = out_data; r = out_round; m = out_mix; l = out_last;
  endtask

  // Drives rounds 10 down to stop_r; the model turns each output into the next input.
  task automatic run_block(input logic [127:0] ct, input int stop_r, output logic [127:0] first_o);
    logic [127:0] x, o, t;
    logic [3:0]   rr;
    logic         m, l;
    x = ct; first_o = '0;
    for (int r = 10; r >= stop_r; r--) begin
      send(x, o, rr, m, l);
      if (r == 10) first_o = o;
      check($sformatf("round_r%0d", r), rr, 128'(r));
      check($sformatf("mix_r%0d", r), m, (r >= 1 && r <= 9) ? 1 : 0);
      check($sformatf("last_r%0d", r), l, (r == 0) ? 1 : 0);
      check($sformatf("xor_r%0d", r), o, x ^ rk(r));
      if (r == 0) check("plaintext", o, C_PT);
      t = (r >= 1 && r <= 9) ? inv_mix(o) : o;
      x = inv_sub(inv_shift(t));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] first, o, x1;
    logic [3:0]   rr;
    logic         m, l;

    rst_n = 1'b0; flush = 1'b0; key_wr_en = 1'b0; key_wr_addr = '0; key_wr_data = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    build_tables();
    build_keys();

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_round", out_round, 0);
    check("rst_out_mix", out_mix, 0);
    check("rst_out_last", out_last, 0);
    check("rst_key_err", key_err, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    load_keys();
    run_block(C_CT, 0, first);
    check("c1_first_beat", first, C_R10);
    @(posedge clk); #1;

    // Backpressure: output held, input stalled, then released.
    x1 = inv_sub(inv_shift(C_CT ^ rk(10)));
    in_valid = 1'b1; in_data = C_CT; out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_first_round", out_round, 10);
    out_ready = 1'b0; in_data = x1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("bp_in_ready_%0d", i), in_ready, 0);
      check($sformatf("bp_hold_data_%0d", i), out_data, C_CT ^ rk(10));
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_next_round", out_round, 9);
    check("bp_next_data", out_data, x1 ^ rk(9));
    @(posedge clk); #1;
    check("bp_no_dup", out_valid, 0);
    do_flush();

    // Rejected key writes: out of range when idle, then in range while busy.
    key_wr_en = 1'b1; key_wr_addr = 6'd44; key_wr_data = 32'hffffffff;
    @(posedge clk); #1;
    key_wr_en = 1'b0;
    check("kerr_range_pulse", key_err, 1);
    @(posedge clk); #1;
    check("kerr_range_clear", key_err, 0);
    send(C_CT, o, rr, m, l);
    key_wr_en = 1'b1; key_wr_addr = 6'd0; key_wr_data = 32'hdeadbeef;
    @(posedge clk); #1;
    key_wr_en = 1'b0;
    check("kerr_busy_pulse", key_err, 1);
    @(posedge clk); #1;
    check("kerr_busy_clear", key_err, 0);
    do_flush();
    run_block(C_CT, 0, first);
    @(posedge clk); #1;

    // Flush at rnd=5 with a beat pending.
    run_block(C_CT, 6, first);
    flush = 1'b1; in_valid = 1'b1; in_data = C_CT;
    @(negedge clk);
    check("flush_in_ready", in_ready, 0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flush_out_valid", out_valid, 0);
    send(C_CT, o, rr, m, l);
    check("flush_next_round", rr, 10);
    check("flush_next_data", o, C_CT ^ rk(10));
    do_flush();

    // Asynchronous reset mid-block.
    run_block(C_CT, 8, first);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_out_data", out_data, 0);
    check("arst_out_round", out_round, 0);
    check("arst_out_mix", out_mix, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(C_PT, o, rr, m, l);
    check("arst_round10", rr, 10);
    check("arst_keys_zero", o, C_PT);
    do_flush();
    load_keys();
    run_block(C_CT, 0, first);
    @(posedge clk); #1;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
